// File: rtl/interp_issue_ctrl.sv
// interp_issue_ctrl: credit-gated pixel issue from the rasterizer into the
// fixed-latency attribute interpolator, with a triangle fence that holds back
// attribute reloads until the previous triangle has drained out of the pipe.
// Ports: aclk/resetn (async active-low); s_axis_* pixel input (tready comb.);
//   m_axis_* registered pixel output; credit_return from the downstream buffer;
//   attr_valid/attr_ready attribute-load handshake; busy; sticky credit_err;
//   stat_pixels/stat_stalls/stat_triangles counters.
// Optional: define INTERP_FLOW_CTRL_STATS_EN to build the statistics counters;
//   otherwise every stat_* output is tied to zero.
module interp_issue_ctrl #(
  parameter int LATENCY = 32,
  parameter int CREDITS = 32,
  parameter int STATS_W = 32
) (
  input  logic               aclk,
  input  logic               resetn,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic [63:0]        s_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic [63:0]        m_axis_tdata,
  input  logic               credit_return,
  input  logic               attr_valid,
  output logic               attr_ready,
  output logic               busy,
  output logic               credit_err,
  output logic [STATS_W-1:0] stat_pixels,
  output logic [STATS_W-1:0] stat_stalls,
  output logic [STATS_W-1:0] stat_triangles
);

  localparam int CW = $clog2(CREDITS + 1);
  // A pixel is counted from its issue edge until it falls out of the
  // LATENCY+1 deep tracker, so at most LATENCY+1 can be outstanding.
  localparam int IW = $clog2(LATENCY + 3);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  typedef enum logic {LOAD, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    credits;
  logic [IW-1:0]    inflight;
  logic [LATENCY:0] track_sr;
  logic             issue;
  logic             retire;
  logic             attr_hs;

  assign s_axis_tready = (state == RUN) && (credits != '0);
  assign attr_ready    = (state == LOAD) && (inflight == '0);
  assign issue         = s_axis_tvalid & s_axis_tready;
  assign retire        = track_sr[LATENCY];
  assign attr_hs       = attr_valid & attr_ready;
  assign busy          = (inflight != '0) || (state == RUN);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= LOAD;
      credits       <= CREDITS_MAX;
      inflight      <= '0;
      track_sr      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      credit_err    <= 1'b0;
    end else begin
      // Triangle fence: attribute reload only from LOAD, pixels only in RUN.
      case (state)
        LOAD: if (attr_hs) state <= RUN;
        RUN:  if (issue && s_axis_tlast) state <= LOAD;
        default: state <= LOAD;
      endcase

      m_axis_tvalid <= issue;
      if (issue) begin
        m_axis_tlast <= s_axis_tlast;
        m_axis_tdata <= s_axis_tdata;
      end

      // A simultaneous issue and return cancel; a return at full count is a
      // protocol violation from downstream and is flagged, not counted.
      if (issue && !credit_return)
        credits <= credits - CW'(1);
      else if (credit_return && !issue && credits != CREDITS_MAX)
        credits <= credits + CW'(1);
      if (credit_return && credits == CREDITS_MAX)
        credit_err <= 1'b1;

      // Mirror of the interpolator valid pipeline.
      track_sr <= {track_sr[LATENCY-1:0], issue};
      case ({issue, retire})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef INTERP_FLOW_CTRL_STATS_EN
  logic stall;
  assign stall = (state == RUN) && s_axis_tvalid && (credits == '0);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      stat_pixels    <= '0;
      stat_stalls    <= '0;
      stat_triangles <= '0;
    end else begin
      if (issue)   stat_pixels    <= stat_pixels + STATS_W'(1);
      if (stall)   stat_stalls    <= stat_stalls + STATS_W'(1);
      if (attr_hs) stat_triangles <= stat_triangles + STATS_W'(1);
    end
  end
`else
  assign stat_pixels    = '0;
  assign stat_stalls    = '0;
  assign stat_triangles = '0;
`endif

endmodule

// File: tb/tb_interp_issue_ctrl.sv
// Testbench for interp_issue_ctrl: randomized and directed pixel/attribute
// traffic against a timestamp-based model of credits, triangle fencing and a
// downstream buffer; issued pixels are checked by a scoreboard monitor.
module tb_interp_issue_ctrl;
  localparam int LAT  = 4;
  localparam int CRED = 4;
  localparam int SW   = 32;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [63:0]   s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [63:0]   m_axis_tdata;
  logic          credit_return = 1'b0;
  logic          attr_valid = 1'b0;
  logic          attr_ready;
  logic          busy;
  logic          credit_err;
  logic [SW-1:0] stat_pixels, stat_stalls, stat_triangles;

  always #5 aclk = ~aclk;

  interp_issue_ctrl #(.LATENCY(LAT), .CREDITS(CRED), .STATS_W(SW)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .credit_return(credit_return),
    .attr_valid(attr_valid), .attr_ready(attr_ready), .busy(busy),
    .credit_err(credit_err), .stat_pixels(stat_pixels),
    .stat_stalls(stat_stalls), .stat_triangles(stat_triangles)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
    int          t;
  } px_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  px_t           sb[$];     // pixels expected on m_axis, with expected cycle
  px_t           mon_e;
  int            pend[$];   // issue cycle of each pixel still inside the interpolator
  int            arr[$];    // cycle each pixel lands in the downstream buffer
  int            landed = 0;
  int            returned = 0;
  bit            m_run = 0;
  bit            m_err = 0;
  bit            m_last_issue = 0;
  int            m_credits = CRED;
  logic [SW-1:0] m_pix = '0, m_stall = '0, m_tri = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_stats();
`ifdef INTERP_FLOW_CTRL_STATS_EN
    chk("stat_pixels", stat_pixels, m_pix);
    chk("stat_stalls", stat_stalls, m_stall);
    chk("stat_triangles", stat_triangles, m_tri);
`else
    chk("stat_pixels", stat_pixels, 0);
    chk("stat_stalls", stat_stalls, 0);
    chk("stat_triangles", stat_triangles, 0);
`endif
  endtask

  // Entries in the downstream buffer that the consumer may pop this cycle.
  function automatic int avail();
    int n = landed - returned;
    foreach (arr[i]) if (arr[i] < cyc) n++;
    return n;
  endfunction

  // Scoreboard monitor: every pixel on m_axis must be the next expected one,
  // in the cycle right after its issue.
  always @(negedge aclk) begin
    if (resetn && m_axis_tvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: pixel %0h with nothing expected (cycle %0d)", m_axis_tdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", m_axis_tdata, mon_e.d);
        chk("out_last", m_axis_tlast, mon_e.l);
        chk("out_cycle", cyc, mon_e.t);
      end
    end
  end

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input logic tv, input logic tl, input logic [63:0] td,
                      input logic av, input logic cr);
    bit iss, ahs, stall;
    int occ;
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    s_axis_tdata  = td;
    attr_valid    = av;
    credit_return = cr;
    @(negedge aclk);
    while (pend.size() > 0 && cyc >= pend[0] + LAT + 2) void'(pend.pop_front());
    while (arr.size() > 0 && arr[0] < cyc) begin
      void'(arr.pop_front());
      landed++;
    end
    chk("s_axis_tready", s_axis_tready, m_run && m_credits != 0);
    chk("attr_ready", attr_ready, !m_run && pend.size() == 0);
    chk("busy", busy, m_run || pend.size() != 0);
    chk("credit_err", credit_err, m_err);
    chk("m_axis_tvalid", m_axis_tvalid, m_last_issue);
    occ = landed - returned + ((arr.size() > 0 && arr[0] == cyc) ? 1 : 0);
    chk("buffer_not_overrun", occ <= CRED, 1);
    chk_stats();

    iss   = tv && m_run && m_credits != 0;
    ahs   = av && !m_run && pend.size() == 0;
    stall = tv && m_run && m_credits == 0;
    if (iss)   m_pix++;
    if (stall) m_stall++;
    if (ahs)   m_tri++;
    if (cr) begin
      if (m_credits == CRED) m_err = 1;
      if (landed > returned) returned++;
    end
    if (iss && !cr) m_credits--;
    else if (cr && !iss && m_credits < CRED) m_credits++;
    if (!m_run && ahs) m_run = 1;
    else if (m_run && iss && tl) m_run = 0;
    if (iss) begin
      sb.push_back('{d: td, l: tl, t: cyc + 1});
      pend.push_back(cyc);
      arr.push_back(cyc + 1 + LAT);
    end
    m_last_issue = iss;
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    attr_valid = 0; credit_return = 0;
    sb.delete(); pend.delete(); arr.delete();
    landed = 0; returned = 0;
    m_run = 0; m_err = 0; m_credits = CRED; m_last_issue = 0;
    m_pix = '0; m_stall = '0; m_tri = '0;
    @(negedge aclk);
    chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
    chk("rst_attr_ready", attr_ready, 1);
    chk("rst_s_axis_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credit_err", credit_err, 0);
    chk_stats();
    @(posedge aclk);
    #1;
    resetn = 1'b1;
    cyc++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Return all credits and let the interpolator empty, bounded.
  task automatic drain(input string name);
    for (int i = 0; i < 200 && !(m_credits == CRED && pend.size() == 0); i++)
      step(0, 0, '0, 0, avail() > 0);
    if (!(m_credits == CRED && pend.size() == 0)) begin
      errors++;
      $display("FAIL %s: drain did not complete, credits %0d required %0d", name, m_credits, CRED);
    end
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rnd64(),
           $urandom_range(0, 1) == 1, (avail() > 0) && ($urandom_range(0, 99) < 55));
  endtask

  initial begin
    do_reset();

    // Attribute load right after reset, then a 6-pixel burst with no returns:
    // four issue, the rest stall.
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, rnd64(), 0, 0);
    for (int i = 0; i < 40 && avail() == 0; i++) step(1, 0, rnd64(), 0, 0);
    if (avail() == 0) begin
      errors++;
      $display("FAIL credit_wait: no entry reached the buffer, avail %0d required >0", avail());
    end
    // Single credit return at zero credits: one issue next cycle, then stall.
    step(0, 0, '0, 0, 1);
    step(1, 0, rnd64(), 0, 0);
    step(1, 0, rnd64(), 0, 0);
    step(1, 0, rnd64(), 0, 0);

    // Return and issue in the same cycle must leave the count unchanged.
    drain("drain_before_last");
    step(1, 0, rnd64(), 0, 0);
    step(1, 0, rnd64(), 0, 0);
    for (int i = 0; i < 20 && avail() == 0; i++) step(0, 0, '0, 0, 0);
    step(1, 0, rnd64(), 0, avail() > 0);
    drain("drain_after_overlap");

    // Triangle fence: last pixel, then attr_valid held until accepted.
    step(1, 1, rnd64(), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);
    step(1, 0, rnd64(), 0, 0);

    random_phase(3000);
    drain("drain_after_random");

    // Spurious return at full credits sets the sticky error.
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // Reset in the middle of a triangle with three pixels in flight.
    for (int i = 0; i < 10 && !m_run; i++) step(0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, rnd64(), 0, 0);
    do_reset();
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, rnd64(), 0, 0);

    random_phase(300);
    drain("drain_final");
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
